// File: rtl/seg_scan_drv.sv
// rtl/seg_scan_drv.sv - four-digit multiplexed seven-segment scan driver
// Double-buffered display data; new values take effect only at frame boundaries.
module seg_scan_drv #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digit_data,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  sel,
  output logic [7:0]  data,
  output logic        frame_done
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [19:0]   pbuf_q, pbuf_d;
  logic          pend_q, pend_d;
  logic [19:0]   shadow_q, shadow_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    data_q, data_d;
  logic          fd_q, fd_d;

  logic          last_blank, last_drive, boundary, lz_blank;
  logic [3:0]    nib;
  logic [3:0]    dp_bits;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'h0: seg_enc = 7'h40;
      4'h1: seg_enc = 7'h79;
      4'h2: seg_enc = 7'h24;
      4'h3: seg_enc = 7'h30;
      4'h4: seg_enc = 7'h19;
      4'h5: seg_enc = 7'h12;
      4'h6: seg_enc = 7'h02;
      4'h7: seg_enc = 7'h78;
      4'h8: seg_enc = 7'h00;
      4'h9: seg_enc = 7'h10;
      4'hA: seg_enc = 7'h08;
      4'hB: seg_enc = 7'h03;
      4'hC: seg_enc = 7'h46;
      4'hD: seg_enc = 7'h21;
      4'hE: seg_enc = 7'h06;
      default: seg_enc = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pbuf_d   = pbuf_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    sel_d    = 4'hF;
    data_d   = 8'hFF;
    fd_d     = 1'b0;

    last_blank = (cnt_q == CW'(BLANK_CYC - 1));
    last_drive = (cnt_q == CW'(SCAN_DIV - 1));
    boundary   = en && (state_q == ST_DRIVE) && last_drive && (idx_q == 2'd3);

    nib     = shadow_q[{idx_q, 2'b00} +: 4];
    dp_bits = shadow_q[19:16];
    case (idx_q)
      2'd3:    lz_blank = blank_lz && (shadow_q[15:12] == 4'h0);
      2'd2:    lz_blank = blank_lz && (shadow_q[15:8] == 8'h00);
      2'd1:    lz_blank = blank_lz && (shadow_q[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase

    if (load) begin
      pbuf_d = {dp_in, digit_data};
      pend_d = 1'b1;
    end
    // Live inputs beat the pending buffer so a load on the boundary cycle is not lost.
    if (boundary) begin
      if (load)        shadow_d = {dp_in, digit_data};
      else if (pend_q) shadow_d = pbuf_q;
      pend_d = 1'b0;
    end

    if (en) begin
      fd_d = boundary;
      if (state_q == ST_BLANK) begin
        if (last_blank) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        sel_d  = ~(4'b0001 << idx_q);
        data_d = {~dp_bits[idx_q], lz_blank ? 7'h7F : seg_enc(nib)};
        if (last_drive) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      pbuf_q   <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      sel_q    <= 4'hF;
      data_q   <= 8'hFF;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pbuf_q   <= pbuf_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      fd_q     <= fd_d;
    end
  end

  assign sel        = sel_q;
  assign data       = data_q;
  assign frame_done = fd_q;

endmodule
